// File: rtl/decode_sign_extend_unit_pkg.sv
// Shared immediate-extension mode encodings for the decode stage.
// The control unit imports these encodings as well.
package decode_sign_extend_unit_pkg;

  localparam logic [1:0] EXT_SIGN   = 2'b00;
  localparam logic [1:0] EXT_ZERO   = 2'b01;
  localparam logic [1:0] EXT_LUI    = 2'b10;
  localparam logic [1:0] EXT_BRANCH = 2'b11;

  localparam int IMM_W_DEFAULT  = 16;
  localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/decode_sign_extend_unit_imm_extend_comb.sv
// Pure combinational mode mux that widens the instruction immediate.
// Branch offsets reuse the sign-extended value and shift it left by two.
module imm_extend_comb
  import decode_sign_extend_unit_pkg::*;
#(
  parameter int IMM_W  = IMM_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        ext_mode,
  output logic [DATA_W-1:0] ext_value,
  output logic              imm_neg
);

  logic [DATA_W-1:0] sign_ext;
  logic [DATA_W-1:0] zero_ext;
  logic [DATA_W-1:0] lui_ext;
  logic [DATA_W-1:0] branch_ext;

  assign imm_neg    = imm[IMM_W-1];
  assign sign_ext   = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign zero_ext   = {{(DATA_W-IMM_W){1'b0}}, imm};
  assign lui_ext    = {imm, {(DATA_W-IMM_W){1'b0}}};
  // Upper bits shifted out here are discarded by design.
  assign branch_ext = sign_ext << 2;

  always_comb begin
    ext_value = sign_ext;
    case (ext_mode)
      EXT_SIGN:   ext_value = sign_ext;
      EXT_ZERO:   ext_value = zero_ext;
      EXT_LUI:    ext_value = lui_ext;
      EXT_BRANCH: ext_value = branch_ext;
      default:    ext_value = sign_ext;
    endcase
  end

endmodule

// File: rtl/decode_sign_extend_unit.sv
// Decode-stage immediate extender: combinational result for the ID operand mux
// plus a stall/flush-aware ID/EX register with asynchronous reset.
module decode_sign_extend_unit
  import decode_sign_extend_unit_pkg::*;
#(
  parameter int IMM_W  = IMM_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IMM_W-1:0]  instruction,
  input  logic [1:0]        ext_mode,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] extended_instruction,
  output logic              imm_neg,
  output logic [DATA_W-1:0] ext_q,
  output logic              valid_q
);

  logic [DATA_W-1:0] ext_reg;
  logic              valid_reg;

  imm_extend_comb #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_imm_extend_comb (
    .imm       (instruction),
    .ext_mode  (ext_mode),
    .ext_value (extended_instruction),
    .imm_neg   (imm_neg)
  );

  // Flush outranks stall; the value loads even for bubbles, valid_q qualifies it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      ext_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (!stall) begin
      ext_reg   <= extended_instruction;
      valid_reg <= valid_in;
    end
  end

  assign ext_q   = ext_reg;
  assign valid_q = valid_reg;

endmodule

// File: tb/tb_decode_sign_extend_unit.sv
// Directed self-checking bench for decode_sign_extend_unit.
// Inputs change 1 time unit after posedge; outputs are sampled away from edges.
module tb_decode_sign_extend_unit;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic [1:0]  ext_mode;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic [31:0] extended_instruction;
  logic        imm_neg;
  logic [31:0] ext_q;
  logic        valid_q;

  int checks = 0;
  int errors = 0;

  decode_sign_extend_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .instruction          (instruction),
    .ext_mode             (ext_mode),
    .valid_in             (valid_in),
    .stall                (stall),
    .flush                (flush),
    .extended_instruction (extended_instruction),
    .imm_neg              (imm_neg),
    .ext_q                (ext_q),
    .valid_q              (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    $display("check %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    instruction = 16'h0000;
    ext_mode    = 2'b00;
    valid_in    = 1'b0;
    stall       = 1'b0;
    flush       = 1'b0;
    #1;
    check32("reset_ext_q", ext_q, 32'h0);
    check1("reset_valid_q", valid_q, 1'b0);

    // Combinational path, all modes
    instruction = 16'h000F; ext_mode = 2'b00; #1;
    check32("sign_000F", extended_instruction, 32'h0000000F);
    check1("neg_000F", imm_neg, 1'b0);
    instruction = 16'h3C0F; #1;
    check32("sign_3C0F", extended_instruction, 32'h00003C0F);
    instruction = 16'h8000; #1;
    check32("sign_8000", extended_instruction, 32'hFFFF8000);
    check1("neg_8000", imm_neg, 1'b1);
    ext_mode = 2'b01; #1;
    check32("zero_8000", extended_instruction, 32'h00008000);
    instruction = 16'h1234; ext_mode = 2'b10; #1;
    check32("lui_1234", extended_instruction, 32'h12340000);
    instruction = 16'hFFFF; ext_mode = 2'b11; #1;
    check32("branch_FFFF", extended_instruction, 32'hFFFFFFFC);
    instruction = 16'h0004; #1;
    check32("branch_0004", extended_instruction, 32'h00000010);
    instruction = 16'hC001; #1;
    check32("branch_C001", extended_instruction, 32'hFFFF0004);

    // Reset still held across an edge
    tick();
    check32("held_reset_ext_q", ext_q, 32'h0);

    // Release reset between edges, then load
    rst = 1'b0;
    instruction = 16'h000F; ext_mode = 2'b00; valid_in = 1'b1;
    tick();
    check32("load_ext_q", ext_q, 32'h0000000F);
    check1("load_valid_q", valid_q, 1'b1);

    // Stall while the input changes
    stall = 1'b1; instruction = 16'h1234; ext_mode = 2'b10; valid_in = 1'b0;
    tick();
    check32("stall_ext_q", ext_q, 32'h0000000F);
    check1("stall_valid_q", valid_q, 1'b1);
    check32("stall_comb", extended_instruction, 32'h12340000);

    // Flush beats stall
    flush = 1'b1;
    tick();
    check32("flush_ext_q", ext_q, 32'h0);
    check1("flush_valid_q", valid_q, 1'b0);

    // Bubble still loads the value
    flush = 1'b0; stall = 1'b0; instruction = 16'hFFFF; ext_mode = 2'b11; valid_in = 1'b0;
    tick();
    check32("bubble_ext_q", ext_q, 32'hFFFFFFFC);
    check1("bubble_valid_q", valid_q, 1'b0);

    instruction = 16'h8000; ext_mode = 2'b00; valid_in = 1'b1;
    tick();
    check32("load2_ext_q", ext_q, 32'hFFFF8000);
    check1("load2_valid_q", valid_q, 1'b1);

    // Asynchronous reset between edges
    #3;
    rst = 1'b1;
    #1;
    check32("async_rst_ext_q", ext_q, 32'h0);
    check1("async_rst_valid_q", valid_q, 1'b0);
    instruction = 16'h1234; ext_mode = 2'b01; #1;
    check32("rst_comb_track", extended_instruction, 32'h00001234);
    tick();
    check32("rst_edge_ext_q", ext_q, 32'h0);
    check1("rst_edge_valid_q", valid_q, 1'b0);

    // Release takes effect at the next edge
    rst = 1'b0;
    tick();
    check32("post_rst_ext_q", ext_q, 32'h00001234);
    check1("post_rst_valid_q", valid_q, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
